// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi traceback controller.
//   VIT_ADDR_W : default traceback bank depth exponent (2**VIT_ADDR_W words)
//   VIT_NBANK  : default number of decision-memory banks (power of two, >= 3)
//   tb_state_t : traceback sequencer states
package viterbi_pkg;

   localparam int VIT_ADDR_W = 5;
   localparam int VIT_NBANK  = 4;

   typedef enum logic [1:0] {
      TB_IDLE,
      TB_START,
      TB_TRAIN,
      TB_DECODE
   } tb_state_t;

endpackage

// File: rtl/viterbi_ptr.sv
// Bank/address pointer into the decision memory.
// Counts one word per step; the address wraps at its terminal value and the
// bank rolls by one (modulo 2**BANK_W) at the same time. DOWN selects the
// direction. A load overrides the step.
//   clk, rst            : clock, async active-low reset (pointer clears to 0)
//   load, load_bank/addr: synchronous preset
//   step                : advance one word
//   bank, addr          : current pointer
//   at_end              : address is at its terminal value (max up / 0 down)
module viterbi_ptr #(
   parameter int   ADDR_W = 5,
   parameter int   BANK_W = 2,
   parameter logic DOWN   = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [BANK_W-1:0] load_bank,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic              step,
   output logic [BANK_W-1:0] bank,
   output logic [ADDR_W-1:0] addr,
   output logic              at_end
);

   assign at_end = DOWN ? (addr == '0) : (addr == '1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bank <= '0;
         addr <= '0;
      end else if (load) begin
         bank <= load_bank;
         addr <= load_addr;
      end else if (step) begin
         if (DOWN) begin
            if (at_end) begin
               addr <= '1;
               bank <= bank - BANK_W'(1);
            end else begin
               addr <= addr - ADDR_W'(1);
            end
         end else begin
            if (at_end) begin
               addr <= '0;
               bank <= bank + BANK_W'(1);
            end else begin
               addr <= addr + ADDR_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/viterbi_ctrl.sv
// Viterbi decoder decision-memory and traceback controller.
// The writer fills banks with ACS decisions; once two banks are complete, each
// newly completed bank launches a traceback that trains over that bank and then
// decodes over the bank before it, both read from the top address downward.
//   clk, rst              : clock, async active-low reset
//   in_valid / in_ready   : symbol handshake into the branch-metric stage
//   acs_en, wr_en         : ACS update enable / decision write strobe (= accept)
//   wr_bank, wr_addr      : decision write pointer
//   tb_start              : one-cycle pulse at traceback launch
//   rd_en, rd_bank, rd_addr: decision read strobe and pointer (read latency 1)
//   dec_valid, dec_last   : decoded bit valid / final bit of a block
module viterbi_ctrl
   import viterbi_pkg::*;
#(
   parameter int  ADDR_W = VIT_ADDR_W,
   parameter int  NBANK  = VIT_NBANK,
   localparam int BANK_W = $clog2(NBANK)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              acs_en,
   output logic              wr_en,
   output logic [BANK_W-1:0] wr_bank,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              tb_start,
   output logic              rd_en,
   output logic [BANK_W-1:0] rd_bank,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              dec_valid,
   output logic              dec_last
);

   tb_state_t         state, state_n;
   logic [1:0]        filled;
   logic              pending;
   logic              accept, complete, trig;
   logic              wr_end, rd_zero;
   logic              busy, final_rd;
   logic              rd_load, rd_step;
   logic [BANK_W-1:0] ld_bank;

   assign busy     = (state == TB_TRAIN) || (state == TB_DECODE);
   assign final_rd = (state == TB_DECODE) && rd_zero;

   // The writer may run freely inside its current bank; it only waits at the
   // last word so it never rolls into a bank a traceback is still reading.
   // The final decode read frees the banks, so completion is allowed there.
   assign in_ready = ~(wr_end & (pending | (busy & ~final_rd)));

   // Gated by reset so no strobe escapes while the block is held in reset.
   assign accept   = in_valid & in_ready & rst;
   assign acs_en   = accept;
   assign wr_en    = accept;
   assign complete = accept & wr_end;
   assign trig     = complete & (filled != 2'd0);

   assign tb_start = (state == TB_START);
   assign rd_en    = busy;

   // During TB_START the writer sits in the bank after the completed one, so
   // the training bank is one behind it. Loading on the START edge keeps the
   // read outputs unchanged until the first training read.
   assign ld_bank = wr_bank - BANK_W'(1);
   assign rd_load = (state == TB_START);
   assign rd_step = busy & ~final_rd;

   viterbi_ptr #(.ADDR_W(ADDR_W), .BANK_W(BANK_W), .DOWN(1'b0)) u_wr_ptr (
      .clk       (clk),
      .rst       (rst),
      .load      (1'b0),
      .load_bank ('0),
      .load_addr ('0),
      .step      (accept),
      .bank      (wr_bank),
      .addr      (wr_addr),
      .at_end    (wr_end)
   );

   // Descending across the train bank's address 0 rolls the bank down by one,
   // which lands exactly on the decode bank.
   viterbi_ptr #(.ADDR_W(ADDR_W), .BANK_W(BANK_W), .DOWN(1'b1)) u_rd_ptr (
      .clk       (clk),
      .rst       (rst),
      .load      (rd_load),
      .load_bank (ld_bank),
      .load_addr ('1),
      .step      (rd_step),
      .bank      (rd_bank),
      .addr      (rd_addr),
      .at_end    (rd_zero)
   );

   always_comb begin
      state_n = state;
      case (state)
         TB_IDLE:   if (trig || pending) state_n = TB_START;
         TB_START:  state_n = TB_TRAIN;
         TB_TRAIN:  if (rd_zero) state_n = TB_DECODE;
         TB_DECODE: if (rd_zero) state_n = (trig || pending) ? TB_START : TB_IDLE;
         default:   state_n = TB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= TB_IDLE;
         filled    <= 2'd0;
         pending   <= 1'b0;
         dec_valid <= 1'b0;
         dec_last  <= 1'b0;
      end else begin
         state <= state_n;
         if (complete && filled != 2'd2) filled <= filled + 2'd1;
         // Pending covers a completed bank until its TB_START cycle retires it.
         if (trig)                      pending <= 1'b1;
         else if (state == TB_START)    pending <= 1'b0;
         dec_valid <= rd_en & (state == TB_DECODE);
         dec_last  <= final_rd;
      end
   end

endmodule
